// File: rtl/bridge_responder_if.sv
// Request/response bundle between the EX-stage load/store initiator and the bridge responder.
// The initiator drives one request per cycle and the responder answers in the next cycle.
interface bridge_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        bus_err;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata,
        input  rd_data, rd_valid, bus_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata,
        output rd_data, rd_valid, bus_err
    );
endinterface

// File: rtl/bridge_responder.sv
// Target side of the data-access bridge: data RAM, memory-mapped timer and its CP0 interrupt.
// Read data is registered so that it arrives one cycle after the load request.
module bridge_responder #(
    parameter int          DM_WORDS = 1024,
    parameter logic [31:0] TMR_BASE = 32'h7F00
) (
    input  logic                i_clk,
    input  logic                i_rst,
    bridge_responder_if.slave   bus,
    output logic                o_tmr_irq
);

    localparam int          AW       = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } tmr_state_t;

    logic [31:0]   r_mem [DM_WORDS];
    logic [31:0]   r_rdData;
    logic          r_rdValid;
    logic          r_busErr;

    // Timer control is kept as {im, mode, en}; other CTRL bits do not exist.
    logic [2:0]    r_ctrl;
    logic [31:0]   r_preset;
    logic [31:0]   r_count;
    logic          r_irq;
    tmr_state_t    r_state;

    logic          w_dmHit;
    logic          w_tmrHit;
    logic [AW-1:0] w_dmIdx;
    logic [1:0]    w_tmrReg;
    logic          w_load;
    logic          w_store;
    logic          w_ctrlWr;
    logic          w_presetWr;
    logic [2:0]    w_ctrlEff;
    logic [31:0]   w_rdWord;
    logic [31:0]   w_countNext;
    tmr_state_t    w_stateNext;

    assign w_dmHit    = bus.req_addr < DM_BYTES;
    assign w_tmrReg   = bus.req_addr[3:2];
    assign w_tmrHit   = (bus.req_addr[31:4] == TMR_BASE[31:4]) && (w_tmrReg != 2'b11);
    assign w_dmIdx    = bus.req_addr[AW+1:2];
    assign w_load     = bus.req_valid && !bus.req_write;
    assign w_store    = bus.req_valid && bus.req_write;
    assign w_ctrlWr   = w_store && w_tmrHit && (w_tmrReg == 2'b00);
    assign w_presetWr = w_store && w_tmrHit && (w_tmrReg == 2'b01);
    assign w_ctrlEff  = w_ctrlWr ? {bus.req_wdata[3], bus.req_wdata[1], bus.req_wdata[0]} : r_ctrl;

    always_ff @(posedge i_clk) begin
        if (w_store && w_dmHit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_be[i]) begin
                    r_mem[w_dmIdx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rdWord = 32'h0;
        if (w_dmHit) begin
            w_rdWord = r_mem[w_dmIdx];
        end else if (w_tmrHit) begin
            case (w_tmrReg)
                2'b00:   w_rdWord = {28'h0, r_ctrl[2], 1'b0, r_ctrl[1], r_ctrl[0]};
                2'b01:   w_rdWord = r_preset;
                2'b10:   w_rdWord = r_count;
                default: w_rdWord = 32'h0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rdData  <= 32'h0;
            r_rdValid <= 1'b0;
            r_busErr  <= 1'b0;
        end else begin
            r_rdValid <= w_load;
            r_busErr  <= bus.req_valid && !w_dmHit && !w_tmrHit;
            if (w_load) begin
                r_rdData <= w_rdWord;
            end
        end
    end

    // A CTRL store overrides the normal step: en=1 restarts through LOAD, en=0 parks in IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        if (w_ctrlWr) begin
            w_stateNext = w_ctrlEff[0] ? S_LOAD : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ctrlEff[0]) begin
                        w_stateNext = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_countNext = r_preset;
                    w_stateNext = S_CNT;
                end
                S_CNT: begin
                    if (!w_ctrlEff[0]) begin
                        w_stateNext = S_IDLE;
                    end else if (r_count > 32'd1) begin
                        w_countNext = r_count - 32'd1;
                    end else begin
                        w_countNext = 32'h0;
                        w_stateNext = S_INT;
                    end
                end
                S_INT: begin
                    if (w_ctrlEff[1]) begin
                        w_stateNext = S_LOAD;
                    end
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= S_IDLE;
            r_ctrl   <= 3'b000;
            r_preset <= 32'h0;
            r_count  <= 32'h0;
            r_irq    <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ctrl  <= w_ctrlEff;
            r_count <= w_countNext;
            r_irq   <= (r_state == S_INT) && r_ctrl[2];
            if (w_presetWr) begin
                r_preset <= bus.req_wdata;
            end
        end
    end

    assign bus.rd_data  = r_rdData;
    assign bus.rd_valid = r_rdValid;
    assign bus.bus_err  = r_busErr;
    assign o_tmr_irq    = r_irq;

endmodule
